baton_tempo_controller: RTL

//  Sequences the baton tracker and turns its raw direction-change flag into a conducted tempo.

---
 rtl/baton_tempo_controller.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/baton_tempo_controller.sv
// ---------------------------------------------------------------------------
// baton_tempo_controller
//   Sequences the baton tracker and turns its raw direction-change flag into a
//   conducted tempo. A free-running sample counter issues measure strobes to
//   the tracker. Rising edges of the tracker's change flag become beats, with
//   a refractory hold-off that rejects noise re-triggers. The beat-to-beat
//   interval is timed, and the mean of the last four intervals is published
//   as the conducted period.
//
// Ports
//   clk_camera_in     in   single clock (camera domain)
//   rst_in            in   synchronous reset, active low (0 = reset)
//   enable_in         in   1 = run tracking, 0 = force IDLE
//   change_in         in   direction-change level from the baton tracker
//   measure_out       out  1-cycle strobe to the tracker measure input
//   beat_out          out  1-cycle pulse per accepted beat
//   period_out        out  mean of last 4 beat intervals, in cycles
//   period_valid_out  out  1 once 4 intervals are held since the last clear
//   tracking_out      out  1 while at least one beat has been seen (HOLDOFF/COUNT)
//   timeout_out       out  1-cycle pulse when the tempo is lost
// ---------------------------------------------------------------------------
module baton_tempo_controller #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int REFRACTORY    = 300000,
  parameter int TIMEOUT       = 4000000,
  parameter int PERIOD_W      = 23
) (
  input  logic                clk_camera_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic                change_in,
  output logic                measure_out,
  output logic                beat_out,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid_out,
  output logic                tracking_out,
  output logic                timeout_out
);

  localparam int SCTR_W = $clog2(SAMPLE_PERIOD);
  // The oldest of the four intervals is dropped on every push, so only the
  // three most recent ones need storage; the fourth is the live ictr value.
  localparam int HIST_KEEP = 3;

  localparam logic [SCTR_W-1:0]   SCTR_LAST = SCTR_W'(SAMPLE_PERIOD - 1);
  localparam logic [SCTR_W-1:0]   SCTR_ONE  = SCTR_W'(1);
  localparam logic [PERIOD_W-1:0] REF_LAST  = PERIOD_W'(REFRACTORY - 1);
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] ICTR_ONE  = PERIOD_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    HOLDOFF    = 2'd2,
    COUNT      = 2'd3
  } state_t;

  state_t              state_reg;
  logic [SCTR_W-1:0]   sctr_reg;
  logic                measure_reg;
  logic                change_q_reg;
  logic [PERIOD_W-1:0] ictr_reg;
  logic [PERIOD_W-1:0] hist_reg [HIST_KEEP];
  logic [2:0]          hist_cnt_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic                period_valid_reg;
  logic                beat_reg;
  logic                timeout_reg;
  logic                tracking_reg;

  logic                event_w;
  logic [PERIOD_W+1:0] hist_ext [HIST_KEEP];
  logic [PERIOD_W+1:0] sum_next;
  logic [2:0]          hist_cnt_next;

  assign event_w = change_in & ~change_q_reg;

  // Zero-extend stored intervals so the 4-entry sum cannot overflow.
  generate
    for (genvar gi = 0; gi < HIST_KEEP; gi++) begin : g_hist_ext
      assign hist_ext[gi] = {2'b00, hist_reg[gi]};
    end
  endgenerate

  // Sum of the history as it will be after pushing the current interval.
  assign sum_next      = {2'b00, ictr_reg} + hist_ext[0] + hist_ext[1] + hist_ext[2];
  assign hist_cnt_next = (hist_cnt_reg == 3'd4) ? 3'd4 : hist_cnt_reg + 3'd1;

  // Sample counter: held at 0 in IDLE so the first strobe lands a full
  // SAMPLE_PERIOD after leaving IDLE.
  always_ff @(posedge clk_camera_in) begin
    if (!rst_in) begin
      sctr_reg     <= '0;
      measure_reg  <= 1'b0;
      change_q_reg <= 1'b0;
    end else begin
      change_q_reg <= change_in;
      if (state_reg == IDLE) begin
        sctr_reg    <= '0;
        measure_reg <= 1'b0;
      end else if (sctr_reg == SCTR_LAST) begin
        sctr_reg    <= '0;
        measure_reg <= 1'b1;
      end else begin
        sctr_reg    <= sctr_reg + SCTR_ONE;
        measure_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_camera_in) begin
    if (!rst_in) begin
      state_reg        <= IDLE;
      ictr_reg         <= '0;
      hist_cnt_reg     <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      beat_reg         <= 1'b0;
      timeout_reg      <= 1'b0;
      tracking_reg     <= 1'b0;
      for (int i = 0; i < HIST_KEEP; i++) hist_reg[i] <= '0;
    end else begin
      beat_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      if (!enable_in) begin
        state_reg        <= IDLE;
        tracking_reg     <= 1'b0;
        ictr_reg         <= '0;
        hist_cnt_reg     <= '0;
        period_reg       <= '0;
        period_valid_reg <= 1'b0;
        for (int i = 0; i < HIST_KEEP; i++) hist_reg[i] <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= WAIT_FIRST;
          end
          WAIT_FIRST: begin
            // First beat only starts the interval timer; nothing is recorded.
            if (event_w) begin
              beat_reg     <= 1'b1;
              ictr_reg     <= ICTR_ONE;
              state_reg    <= HOLDOFF;
              tracking_reg <= 1'b1;
            end
          end
          HOLDOFF: begin
            ictr_reg <= ictr_reg + ICTR_ONE;
            if (ictr_reg == REF_LAST) state_reg <= COUNT;
          end
          COUNT: begin
            // An event on the timeout cycle still counts as a beat.
            if (event_w) begin
              beat_reg     <= 1'b1;
              hist_reg[0]  <= ictr_reg;
              for (int i = 1; i < HIST_KEEP; i++) hist_reg[i] <= hist_reg[i-1];
              hist_cnt_reg <= hist_cnt_next;
              if (hist_cnt_next == 3'd4) begin
                period_reg       <= sum_next[PERIOD_W+1:2];
                period_valid_reg <= 1'b1;
              end else begin
                period_reg       <= '0;
                period_valid_reg <= 1'b0;
              end
              ictr_reg  <= ICTR_ONE;
              state_reg <= HOLDOFF;
            end else if (ictr_reg == TIMEOUT_V) begin
              timeout_reg      <= 1'b1;
              hist_cnt_reg     <= '0;
              period_reg       <= '0;
              period_valid_reg <= 1'b0;
              for (int i = 0; i < HIST_KEEP; i++) hist_reg[i] <= '0;
              state_reg        <= WAIT_FIRST;
              tracking_reg     <= 1'b0;
            end else begin
              ictr_reg <= ictr_reg + ICTR_ONE;
            end
          end
          default: begin
            state_reg    <= IDLE;
            tracking_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign measure_out      = measure_reg;
  assign beat_out         = beat_reg;
  assign period_out       = period_reg;
  assign period_valid_out = period_valid_reg;
  assign tracking_out     = tracking_reg;
  assign timeout_out      = timeout_reg;

endmodule
